// File: rtl/hazard_pkg.sv
// Shared state encoding and control output sets for the hazard control unit.
// Optional perf counters are enabled with HAZARD_PERF_EN.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic pcwrite;
        logic ifidwrite;
        logic ifflush;
        logic idbubble;
    } ctl_t;

    localparam ctl_t CTL_NORMAL    = 4'b1100;
    localparam ctl_t CTL_FREEZE    = 4'b0000;
    localparam ctl_t CTL_FLUSHO    = 4'b1110;
    localparam ctl_t CTL_LOADSTALL = 4'b0001;
    localparam ctl_t CTL_RESET     = 4'b0011;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side signals of the hazard control unit.
// HAZARD_PERF_EN adds the StallCount/FlushCount outputs.
interface hazard_control_unit_if #(
    parameter int REG_W = 4
);
    logic             IDEXMemRead;
    logic [REG_W-1:0] IDEXRd;
    logic [REG_W-1:0] IFIDRs;
    logic [REG_W-1:0] IFIDRt;
    logic             BranchTaken;
    logic             MemBusy;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IFFlush;
    logic             IDBubble;
`ifdef HAZARD_PERF_EN
    logic [15:0]      StallCount;
    logic [15:0]      FlushCount;

    modport master (
        output IDEXMemRead, IDEXRd, IFIDRs, IFIDRt,
        output BranchTaken, MemBusy,
        input  PCWrite, IFIDWrite, IFFlush, IDBubble,
        input  StallCount, FlushCount
    );
    modport slave (
        input  IDEXMemRead, IDEXRd, IFIDRs, IFIDRt,
        input  BranchTaken, MemBusy,
        output PCWrite, IFIDWrite, IFFlush, IDBubble,
        output StallCount, FlushCount
    );
`else
    modport master (
        output IDEXMemRead, IDEXRd, IFIDRs, IFIDRt,
        output BranchTaken, MemBusy,
        input  PCWrite, IFIDWrite, IFFlush, IDBubble
    );
    modport slave (
        input  IDEXMemRead, IDEXRd, IFIDRs, IFIDRt,
        input  BranchTaken, MemBusy,
        output PCWrite, IFIDWrite, IFFlush, IDBubble
    );
`endif
endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard comparator; register 0 never creates a dependency.
module hazard_detect #(
    parameter int REG_W = 4
) (
    input  logic             memread,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    output logic             hazard
);
    assign hazard = memread && (rd != '0) && ((rd == rs) || (rd == rt));
endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush/freeze controller for the IF/ID front end.
// HAZARD_PERF_EN adds saturating stall and flush cycle counters.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int REG_W        = 4,
    parameter int FLUSH_CYCLES = 1
) (
    input logic                  clk,
    input logic                  rst,
    hazard_control_unit_if.slave bus
);

    state_t     state, state_n;
    logic [1:0] count, count_n;
    logic       pend, pend_n;
    logic       hazard;
    logic       do_run, do_flush;
    ctl_t       ctl;

    hazard_detect #(.REG_W(REG_W)) u_detect (
        .memread (bus.IDEXMemRead),
        .rd      (bus.IDEXRd),
        .rs      (bus.IFIDRs),
        .rt      (bus.IFIDRt),
        .hazard  (hazard)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            count <= 2'd0;
            pend  <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            pend  <= pend_n;
        end
    end

    always_comb begin
        ctl      = CTL_NORMAL;
        state_n  = state;
        count_n  = count;
        pend_n   = pend;
        do_run   = 1'b0;
        do_flush = 1'b0;
        unique case (state)
            RUN: do_run = 1'b1;
            FLUSH: begin
                if (bus.MemBusy) begin
                    ctl = CTL_FREEZE;
                end else begin
                    ctl     = CTL_FLUSHO;
                    count_n = count - 2'd1;
                    if (count == 2'd1) state_n = RUN;
                end
            end
            MEMWAIT: begin
                if (bus.MemBusy) begin
                    ctl = CTL_FREEZE;
                    if (bus.BranchTaken) pend_n = 1'b1;
                end else if (pend) begin
                    pend_n   = 1'b0;
                    do_flush = 1'b1;
                end else begin
                    do_run = 1'b1;
                end
            end
            default: state_n = RUN;
        endcase
        if (do_run) begin
            state_n = RUN;
            if (bus.MemBusy) begin
                ctl     = CTL_FREEZE;
                state_n = MEMWAIT;
                pend_n  = bus.BranchTaken;
            end else if (bus.BranchTaken) begin
                do_flush = 1'b1;
            end else if (hazard) begin
                ctl = CTL_LOADSTALL;
            end
        end
        // Taken branch: first flush cycle now, the rest counted down in FLUSH
        if (do_flush) begin
            ctl = CTL_FLUSHO;
            if (FLUSH_CYCLES > 1) begin
                state_n = FLUSH;
                count_n = 2'(FLUSH_CYCLES - 1);
            end else begin
                state_n = RUN;
            end
        end
        if (rst) ctl = CTL_RESET;
    end

    assign bus.PCWrite   = ctl.pcwrite;
    assign bus.IFIDWrite = ctl.ifidwrite;
    assign bus.IFFlush   = ctl.ifflush;
    assign bus.IDBubble  = ctl.idbubble;

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_q, flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            if (!ctl.pcwrite && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
            if (ctl.ifflush && flush_q != 16'hFFFF)
                flush_q <= flush_q + 16'd1;
        end
    end

    assign bus.StallCount = stall_q;
    assign bus.FlushCount = flush_q;
`endif

endmodule
